// File: rtl/sr_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sr_tap_sequencer
// Brief    : Accepts one sample, pulses the tap shift register, then streams
//            every tap (newest first) to the MAC over valid/ready.
//            Optional build macro SR_TAP_ZERO_FILL_EN masks taps not yet filled.
// Revision : 1.0 - initial release
// ============================================================================
module sr_tap_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      in_ready,
    output logic                      sr_shift,
    output logic [DATA_WIDTH-1:0]     sr_din,
    output logic [$clog2(SIZE)-1:0]   sr_address,
    input  logic [DATA_WIDTH-1:0]     sr_dout,
    output logic                      tap_valid,
    input  logic                      tap_ready,
    output logic [DATA_WIDTH-1:0]     tap_data,
    output logic [$clog2(SIZE)-1:0]   tap_index,
    output logic                      tap_last,
    output logic [$clog2(SIZE):0]     fill_count
);

    localparam int AW = $clog2(SIZE);
    localparam logic [AW-1:0] ADDR_LAST = AW'(SIZE - 1);
    localparam logic [AW:0]   FILL_MAX  = (AW + 1)'(SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_q,  hold_d;
    logic [AW-1:0]           addr_q,  addr_d;
    logic [AW:0]             fill_q,  fill_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            addr_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        fill_d  = fill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
                addr_d  = '0;
                state_d = ST_SWEEP;
            end
            ST_SWEEP: begin
                // Wrap happens only here, on the last tap's handshake.
                if (tap_ready) begin
                    if (addr_q == ADDR_LAST) begin
                        addr_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        // in_ready is gated by the raw reset so it reads 0 while held in reset.
        in_ready   = rst && (state_q == ST_IDLE);
        sr_shift   = (state_q == ST_SHIFT);
        sr_din     = hold_q;
        sr_address = addr_q;
        tap_valid  = (state_q == ST_SWEEP);
        tap_index  = addr_q;
        tap_last   = (state_q == ST_SWEEP) && (addr_q == ADDR_LAST);
        fill_count = fill_q;
`ifdef SR_TAP_ZERO_FILL_EN
        // fill_q already includes the sample shifted just before this sweep.
        tap_data   = ({1'b0, addr_q} >= fill_q) ? '0 : sr_dout;
`else
        tap_data   = sr_dout;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_tap_sequencer
// Brief    : Scoreboard bench for sr_tap_sequencer with SIZE=4 and SIZE=64
//            instances, each attached to a behavioural shift register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_tap_sequencer;

`ifdef SR_TAP_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  index;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic preload;

    logic        in_valid4, in_ready4, sr_shift4, tap_valid4, tap_ready4, tap_last4;
    logic [15:0] in_data4, sr_din4, sr_dout4, tap_data4;
    logic [1:0]  sr_address4, tap_index4;
    logic [2:0]  fill_count4;

    logic        in_valid64, in_ready64, sr_shift64, tap_valid64, tap_ready64, tap_last64;
    logic [15:0] in_data64, sr_din64, sr_dout64, tap_data64;
    logic [5:0]  sr_address64, tap_index64;
    logic [6:0]  fill_count64;

    logic [15:0] reg4 [4];
    logic [15:0] reg64 [64];

    exp_t        q4[$];
    exp_t        q64[$];
    logic [15:0] m4 [4];
    logic [15:0] m64 [64];
    int          fill4, fill64;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int shifts4 = 0;
    int last_shift4 = 0;

    sr_tap_sequencer #(.DATA_WIDTH(16), .SIZE(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .sr_shift(sr_shift4), .sr_din(sr_din4), .sr_address(sr_address4), .sr_dout(sr_dout4),
        .tap_valid(tap_valid4), .tap_ready(tap_ready4), .tap_data(tap_data4),
        .tap_index(tap_index4), .tap_last(tap_last4), .fill_count(fill_count4)
    );

    sr_tap_sequencer #(.DATA_WIDTH(16), .SIZE(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid64), .in_data(in_data64), .in_ready(in_ready64),
        .sr_shift(sr_shift64), .sr_din(sr_din64), .sr_address(sr_address64), .sr_dout(sr_dout64),
        .tap_valid(tap_valid64), .tap_ready(tap_ready64), .tap_data(tap_data64),
        .tap_index(tap_index64), .tap_last(tap_last64), .fill_count(fill_count64)
    );

    // Behavioural tapped shift registers; index 0 holds the newest sample.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4; i++) reg4[i] <= 16'hFFFF;
        end else if (sr_shift4) begin
            reg4[0] <= sr_din4;
            for (int i = 1; i < 4; i++) reg4[i] <= reg4[i-1];
        end
    end
    assign sr_dout4 = reg4[sr_address4];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) reg64[i] <= 16'hFFFF;
        end else if (sr_shift64) begin
            reg64[0] <= sr_din64;
            for (int i = 1; i < 64; i++) reg64[i] <= reg64[i-1];
        end
    end
    assign sr_dout64 = reg64[sr_address64];

    always @(posedge clk) begin
        cyc++;
        if (sr_shift4) shifts4++;
    end

    task automatic send4(input logic [15:0] s, input logic [3:0] pat,
                         input bit keep_valid, input int abort_idx);
        int n;
        int k;
        bit stalled;
        logic [15:0] sd;
        logic [1:0]  si;
        exp_t e;
        in_valid4 = 1'b1;
        in_data4  = s;
        n = 0;
        while (!in_ready4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (in_ready4 !== 1'b1) begin
            miscompares++;
            $display("FAIL accept4: in_ready=%b required 1 within 200 cycles", in_ready4);
            in_valid4 = 1'b0;
            return;
        end
        for (int i = 3; i > 0; i--) m4[i] = m4[i-1];
        m4[0] = s;
        if (fill4 < 4) fill4++;
        for (int i = 0; i < 4; i++) begin
            e.data  = (ZF && i >= fill4) ? 16'h0000 : m4[i];
            e.index = 6'(i);
            e.last  = (i == 3);
            q4.push_back(e);
        end
        @(posedge clk); #1;
        last_shift4 = cyc;
        vectors++;
        if (sr_shift4 !== 1'b1 || sr_din4 !== s || in_ready4 !== 1'b0) begin
            miscompares++;
            $display("FAIL shift4: sr_shift=%b sr_din=%h in_ready=%b required 1 %h 0",
                     sr_shift4, sr_din4, in_ready4, s);
        end
        if (keep_valid) in_data4 = s ^ 16'h5A5A;
        else            in_valid4 = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (tap_valid4 !== 1'b1 || tap_index4 !== 2'd0) begin
            miscompares++;
            $display("FAIL latency4: tap_valid=%b tap_index=%0d required 1 0", tap_valid4, tap_index4);
        end
        k = 0;
        stalled = 1'b0;
        sd = '0;
        si = '0;
        while (q4.size() > 0 && k < 100) begin
            if (stalled) begin
                vectors++;
                if (tap_data4 !== sd || tap_index4 !== si) begin
                    miscompares++;
                    $display("FAIL stall4: data=%h index=%0d required %h %0d", tap_data4, tap_index4, sd, si);
                end
            end
            if (abort_idx >= 0 && int'(tap_index4) == abort_idx) begin
                #2;
                rst = 1'b0;
                #1;
                vectors++;
                if (tap_valid4 !== 1'b0 || sr_shift4 !== 1'b0 || sr_address4 !== 2'd0 ||
                    tap_index4 !== 2'd0 || tap_last4 !== 1'b0 || fill_count4 !== 3'd0 ||
                    in_ready4 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL async_rst4: valid=%b shift=%b addr=%0d idx=%0d last=%b fill=%0d rdy=%b required all 0",
                             tap_valid4, sr_shift4, sr_address4, tap_index4, tap_last4, fill_count4, in_ready4);
                end
                q4.delete();
                fill4 = 0;
                fill64 = 0;
                in_valid4 = 1'b0;
                tap_ready4 = 1'b0;
                return;
            end
            vectors++;
            if (sr_shift4 !== 1'b0 || in_ready4 !== 1'b0 || tap_valid4 !== 1'b1) begin
                miscompares++;
                $display("FAIL sweep4: sr_shift=%b in_ready=%b tap_valid=%b required 0 0 1",
                         sr_shift4, in_ready4, tap_valid4);
            end
            tap_ready4 = pat[k % 4];
            stalled = !tap_ready4;
            sd = tap_data4;
            si = tap_index4;
            if (tap_ready4) begin
                e = q4.pop_front();
                vectors++;
                if (tap_data4 !== e.data || {4'b0, tap_index4} !== e.index || tap_last4 !== e.last) begin
                    miscompares++;
                    $display("FAIL tap4: data=%h idx=%0d last=%b required %h %0d %b",
                             tap_data4, tap_index4, tap_last4, e.data, e.index, e.last);
                end
            end
            @(posedge clk); #1;
            k++;
        end
        tap_ready4 = 1'b0;
        vectors++;
        if (q4.size() != 0 || in_ready4 !== 1'b1) begin
            miscompares++;
            $display("FAIL end4: pending=%0d in_ready=%b required 0 1", q4.size(), in_ready4);
            q4.delete();
        end
    endtask

    task automatic send64(input logic [15:0] s);
        int n;
        int k;
        exp_t e;
        in_valid64 = 1'b1;
        in_data64  = s;
        n = 0;
        while (!in_ready64 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (in_ready64 !== 1'b1) begin
            miscompares++;
            $display("FAIL accept64: in_ready=%b required 1 within 200 cycles", in_ready64);
            in_valid64 = 1'b0;
            return;
        end
        for (int i = 63; i > 0; i--) m64[i] = m64[i-1];
        m64[0] = s;
        if (fill64 < 64) fill64++;
        for (int i = 0; i < 64; i++) begin
            e.data  = (ZF && i >= fill64) ? 16'h0000 : m64[i];
            e.index = 6'(i);
            e.last  = (i == 63);
            q64.push_back(e);
        end
        @(posedge clk); #1;
        in_valid64  = 1'b0;
        tap_ready64 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (fill_count64 !== 7'(fill64)) begin
            miscompares++;
            $display("FAIL fill64: fill_count=%0d required %0d", fill_count64, fill64);
        end
        k = 0;
        while (q64.size() > 0 && k < 200) begin
            e = q64.pop_front();
            vectors++;
            if (tap_valid64 !== 1'b1 || tap_data64 !== e.data || tap_index64 !== e.index ||
                tap_last64 !== e.last) begin
                miscompares++;
                $display("FAIL tap64: valid=%b data=%h idx=%0d last=%b required 1 %h %0d %b",
                         tap_valid64, tap_data64, tap_index64, tap_last64, e.data, e.index, e.last);
            end
            @(posedge clk); #1;
            k++;
        end
        tap_ready64 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        preload = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; tap_ready4 = 1'b0;
        in_valid64 = 1'b0; in_data64 = '0; tap_ready64 = 1'b0;
        for (int i = 0; i < 4; i++)  m4[i]  = 16'hFFFF;
        for (int i = 0; i < 64; i++) m64[i] = 16'hFFFF;
        fill4 = 0;
        fill64 = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready4 !== 1'b0 || in_ready64 !== 1'b0 || tap_valid4 !== 1'b0 || sr_shift4 !== 1'b0 ||
            sr_address4 !== 2'd0 || tap_last4 !== 1'b0 || tap_index4 !== 2'd0 || fill_count4 !== 3'd0) begin
            miscompares++;
            $display("FAIL in_reset: rdy=%b rdy64=%b valid=%b shift=%b addr=%0d last=%b idx=%0d fill=%0d required all 0",
                     in_ready4, in_ready64, tap_valid4, sr_shift4, sr_address4, tap_last4, tap_index4, fill_count4);
        end
        preload = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready4 !== 1'b1) begin
            miscompares++;
            $display("FAIL release: in_ready=%b required 1", in_ready4);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (in_ready4 !== 1'b1 || tap_valid4 !== 1'b0 || sr_shift4 !== 1'b0 || fill_count4 !== 3'd0) begin
                miscompares++;
                $display("FAIL idle%0d: rdy=%b valid=%b shift=%b fill=%0d required 1 0 0 0",
                         c, in_ready4, tap_valid4, sr_shift4, fill_count4);
            end
        end
    endtask

    // Register preloaded with 0xFFFF: second sweep is 6,5,0,0 with masking, else 6,5,FFFF,FFFF.
    task automatic test_zero_fill;
        send4(16'h0005, 4'b1111, 1'b0, -1);
        send4(16'h0006, 4'b1111, 1'b0, -1);
        vectors++;
        if (fill_count4 !== 3'd2) begin
            miscompares++;
            $display("FAIL zf_fill: fill_count=%0d required 2", fill_count4);
        end
    endtask

    task automatic test_back_to_back;
        int s0;
        int t1;
        int t2;
        s0 = shifts4;
        send4(16'h0011, 4'b1111, 1'b0, -1);
        t1 = last_shift4;
        send4(16'h0022, 4'b1111, 1'b0, -1);
        t2 = last_shift4;
        vectors++;
        if (t2 - t1 != 6) begin
            miscompares++;
            $display("FAIL period1: shift spacing=%0d required 6", t2 - t1);
        end
        send4(16'h0033, 4'b1111, 1'b0, -1);
        vectors++;
        if (last_shift4 - t2 != 6) begin
            miscompares++;
            $display("FAIL period2: shift spacing=%0d required 6", last_shift4 - t2);
        end
        vectors++;
        if (shifts4 - s0 != 3) begin
            miscompares++;
            $display("FAIL shift_count: pulses=%0d required 3", shifts4 - s0);
        end
    endtask

    task automatic test_stall;
        send4(16'h1234, 4'b1001, 1'b1, -1);
        send4(16'h1234 ^ 16'h5A5A, 4'b1001, 1'b0, -1);
    endtask

    task automatic test_async_reset;
        send4(16'h0077, 4'b1111, 1'b0, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (fill_count4 !== 3'd0 || in_ready4 !== 1'b1) begin
            miscompares++;
            $display("FAIL post_rst: fill=%0d in_ready=%b required 0 1", fill_count4, in_ready4);
        end
        send4(16'h0088, 4'b1111, 1'b0, -1);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 70; i++) send64(16'(i * 37 + 1));
        vectors++;
        if (fill_count64 !== 7'd64) begin
            miscompares++;
            $display("FAIL saturate: fill_count=%0d required 64", fill_count64);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_fill();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_tap_sequencer.md
Name: sr_tap_sequencer

Overview:
Control and read-out engine for the tapped sample shift register in the FIR datapath.
- Accepts one input sample per handshake and pulses the register's shift with that sample on its data input.
- Then walks the register's read address from 0 to size-1 and streams each tap to the MAC stage over a valid/ready interface.
- Sits between the sample source and the MAC/accumulator; the register itself stays a dumb storage element.

Parameters:
dataWidth, 16, sample width in bits
size, 64, number of taps in the attached shift register (power of two, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
in_valid  input  1  sample source has a sample
in_data  input  dataWidth  sample value
in_ready  output  1  sequencer can accept a sample
sr_shift  output  1  shift enable to the shift register
sr_din  output  dataWidth  data input to the shift register
sr_address  output  $clog2(size)  tap read address to the shift register
sr_dout  input  dataWidth  tap read data from the shift register (combinational on sr_address)
tap_valid  output  1  tap_data/tap_index/tap_last are valid
tap_ready  input  1  MAC accepts the current tap
tap_data  output  dataWidth  tap value
tap_index  output  $clog2(size)  tap number 0..size-1 (0 = newest sample)
tap_last  output  1  current tap is index size-1
fill_count  output  $clog2(size)+1  samples shifted in since reset, saturating at size

Behaviour:
- Reset (rst=0, asynchronous) forces the following, and any in-progress sweep is abandoned:
  - state IDLE
  - in_ready=0 during reset, 1 in the first cycle after release
  - sr_shift=0, sr_address=0, tap_valid=0, tap_last=0, tap_index=0, fill_count=0
- FSM states are IDLE, SHIFT and SWEEP.
- IDLE:
  - in_ready=1.
  - in_valid=1 captures in_data into a holding register and moves to SHIFT.
- SHIFT (exactly 1 cycle):
  - sr_shift=1 and sr_din = held sample; in_ready=0.
  - fill_count increments unless already equal to size.
  - Next state is SWEEP with the address counter at 0.
- SWEEP:
  - sr_address = address counter.
  - tap_valid=1, tap_data=sr_dout, tap_index=address counter, tap_last=(counter==size-1).
  - A handshake occurs when tap_valid and tap_ready are both 1.
  - On a handshake with tap_last=0, the counter increments.
  - On a handshake with tap_last=1, the counter returns to 0 and the state returns to IDLE.
  - tap_ready=0 holds all tap outputs stable (no combinational change while stalled).
- sr_shift is 0 in every state except SHIFT. The register contents are frozen during SWEEP, so all size taps belong to the same snapshot.
- in_ready is 0 in SHIFT and SWEEP. Samples presented then are not consumed and must be held by the source.
- Minimum sample period is size+2 cycles with tap_ready held at 1: 1 accept + 1 shift + size sweep cycles.
- Latency: a sample accepted in cycle t appears as tap_index 0 in cycle t+2.
- The address counter width is exactly $clog2(size). The wrap from size-1 to 0 happens only through tap_last handling, never by free overflow.
- sr_din holds its last value outside SHIFT (don't-care for the register, but must be stable).

Optional Feature:
Macro: SR_TAP_ZERO_FILL_EN
- Defined: during the start-up period, taps with tap_index >= fill_count (counted after the current shift) output tap_data=0 regardless of sr_dout. This keeps uninitialised or stale register contents out of the MAC.
- Not defined: tap_data always equals sr_dout, and fill_count is still provided.

Test Plan:
1. Reset release, no input -> in_ready=1, tap_valid=0, sr_shift=0, fill_count=0 held for 10 cycles.
2. size=4, tap_ready=1, samples 0x0011, 0x0022, 0x0033 back-to-back:
   - sr_shift pulses exactly once per sample, 6 cycles apart.
   - Third sweep emits taps 0x0033, 0x0022, 0x0011, then index 3 value.
   - tap_last high only on index 3.
3. tap_ready toggling 1,0,0,1 during a sweep -> tap_data/tap_index unchanged across stalls, no index skipped or repeated, in_valid held high is not accepted until after tap_last handshake.
4. rst driven low asynchronously mid-sweep at index 2 -> all outputs reach reset values before the next clock edge, fill_count=0, next sweep starts at index 0.
5. 70 samples with size=64 -> fill_count saturates at 64 and stays, sweeps continue normally.
6. SR_TAP_ZERO_FILL_EN defined, size=4, register preloaded with 0xFFFF, 2 samples 0x0005, 0x0006 -> second sweep yields 0x0006, 0x0005, 0x0000, 0x0000. Macro undefined, same stimulus -> indices 2 and 3 show 0xFFFF.
